// File: rtl/spi_main.sv
// SPI main controller: serialises a parallel word MSB-first on sdi while capturing sdo,
// then issues one cs-high sclk pulse so the subordinate can clear its bit counters.
module spi_main #(
   parameter int DATA_WIDTH = 128,
   parameter int CLK_DIV    = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] tx_data,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  cs,
   output logic                  sclk,
   output logic                  sdi,
   input  logic                  sdo
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, FLUSH} state_t;

   state_t                state_q, state_d;
   logic [DIV_W-1:0]      div_q, div_d;
   logic [BIT_W-1:0]      bit_q, bit_d;
   logic [DATA_WIDTH-1:0] tx_q, tx_d;
   logic [DATA_WIDTH-1:0] rx_q, rx_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                  sdi_q, sdi_d;
   logic                  done_q, done_d;
   logic                  div_last;

   assign div_last = (div_q == DIV_MAX);

   // Reset lands in FLUSH so a dummy pulse always follows reset release.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= FLUSH;
         div_q     <= '0;
         bit_q     <= '0;
         tx_q      <= '0;
         rx_q      <= '0;
         rx_data_q <= '0;
         sdi_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         bit_q     <= bit_d;
         tx_q      <= tx_d;
         rx_q      <= rx_d;
         rx_data_q <= rx_data_d;
         sdi_q     <= sdi_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      bit_d     = bit_q;
      tx_d      = tx_q;
      rx_d      = rx_q;
      rx_data_d = rx_data_q;
      sdi_d     = sdi_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            sdi_d = 1'b0;
            if (start) begin
               tx_d    = tx_data;
               rx_d    = '0;
               div_d   = '0;
               bit_d   = '0;
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (div_last) begin
               div_d   = '0;
               sdi_d   = tx_q[DATA_WIDTH-1];
               tx_d    = tx_q << 1;
               state_d = HIGH;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         HIGH: begin
            // The falling-edge capture happens on the transition into LOW.
            if (div_last) begin
               div_d   = '0;
               rx_d    = {rx_q[DATA_WIDTH-2:0], sdo};
               state_d = LOW;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         LOW: begin
            if (div_last) begin
               div_d = '0;
               if (bit_q == BIT_MAX) begin
                  bit_d   = '0;
                  sdi_d   = 1'b0;
                  state_d = HOLD;
               end else begin
                  bit_d   = bit_q + BIT_W'(1);
                  sdi_d   = tx_q[DATA_WIDTH-1];
                  tx_d    = tx_q << 1;
                  state_d = HIGH;
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         HOLD: begin
            if (div_last) begin
               div_d     = '0;
               bit_d     = '0;
               rx_data_d = rx_q;
               done_d    = 1'b1;
               state_d   = FLUSH;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         FLUSH: begin
            // bit_q doubles as the flush phase: 0 = sclk high half, 1 = low half.
            sdi_d = 1'b0;
            if (div_last) begin
               div_d = '0;
               if (bit_q == '0) begin
                  bit_d = BIT_W'(1);
               end else begin
                  bit_d   = '0;
                  state_d = IDLE;
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         default: state_d = FLUSH;
      endcase
   end

   assign busy    = (state_q != IDLE);
   assign cs      = (state_q == IDLE) || (state_q == FLUSH);
   assign sclk    = ~reset & ((state_q == HIGH) || ((state_q == FLUSH) && (bit_q == '0)));
   assign sdi     = sdi_q;
   assign done    = done_q;
   assign rx_data = rx_data_q;

endmodule
